// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the Wishbone framebuffer writer.
//   pixel_t        : 24-bit RGB pixel
//   state_t        : capture FSM states
//   WB_*           : constant Wishbone qualifiers driven by the writer
//   grid_pixel()   : grid pattern colour from the low 4 bits of x/y
package frame_writer_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic {
    WAIT_VS = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  localparam logic [3:0] WB_SEL_ALL     = 4'hF;
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  // White on every 16th column/row, black elsewhere.
  function automatic pixel_t grid_pixel(input logic [3:0] x_lo, input logic [3:0] y_lo);
    return ((x_lo == 4'd0) || (y_lo == 4'd0)) ? 24'hFFFFFF : 24'h000000;
  endfunction

endpackage

// File: rtl/frame_writer_fifo.sv
// Synchronous FIFO, 2**DEPTH_W entries of DATA_W bits.
//   push/din  : write when not full, or when full together with a pop
//   pop/dout  : dout is the head entry; pop removes it (ignored when empty)
//   full/empty: occupancy flags derived from the registered count
module frame_writer_fifo #(
  parameter int unsigned DEPTH_W = 4,
  parameter int unsigned DATA_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;
  localparam int unsigned CNT_W = DEPTH_W + 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_wr;
  logic               w_rd;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign w_rd  = pop & ~empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_wr  = push & (~full | w_rd);
  assign dout  = r_mem[r_rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + DEPTH_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wshb_frame_writer.sv
// Wishbone classic master writing an active-pixel stream into a linear
// framebuffer (one 32-bit word per pixel, byte address 4*(line*HDISP+pixel)).
// Optional grid test pattern: define FRAME_WRITER_PATTERN_EN.
//   clk, rst_n           : clock, asynchronous active-low reset
//   vid_rgb/blank/vs     : pixel, active qualifier (1 = active), vsync (active low)
//   pattern_sel          : replace pixels by the grid (pattern build only)
//   wb_*                 : Wishbone master, single-beat writes
//   frame_done           : pulse the cycle after the last pixel of a frame is acked
//   overflow             : sticky, a pixel was dropped on a full FIFO
module wshb_frame_writer
  import frame_writer_pkg::*;
#(
  parameter int unsigned HDISP   = 800,
  parameter int unsigned VDISP   = 480,
  parameter int unsigned DEPTH_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] vid_rgb,
  input  logic        vid_blank,
  input  logic        vid_vs,
  input  logic        pattern_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_ms,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  output logic        wb_stb,
  output logic        wb_cyc,
  input  logic        wb_ack,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned NPIX   = HDISP * VDISP;
  localparam int unsigned CNT_W  = $clog2(NPIX) + 1;
  localparam int unsigned DATA_W = CNT_W + 24;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_vs_q;
  logic               w_vs_fall;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  pixel_t             w_pix;
  logic [DATA_W-1:0]  w_din;
  logic [DATA_W-1:0]  w_dout;
  logic [CNT_W-1:0]   w_head_idx;
  logic               w_head_last;
  logic [31:0]        r_adr;
  logic               r_frame_done;
  logic               r_overflow;

  assign w_vs_fall = r_vs_q & ~vid_vs;

  // FSM state and pixel counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_VS;
      r_cnt   <= '0;
      r_vs_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vs_q  <= vid_vs;
    end
  end

  // Next state, counter and push decision. The vsync edge cycle itself never pushes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    case (r_state)
      WAIT_VS: begin
        if (w_vs_fall) begin
          w_state_nxt = CAPTURE;
          w_cnt_nxt   = '0;
        end
      end
      CAPTURE: begin
        if (w_vs_fall) begin
          w_cnt_nxt = '0;
        end else if (vid_blank && (r_cnt < CNT_W'(NPIX))) begin
          w_push    = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = WAIT_VS;
    endcase
  end

`ifdef FRAME_WRITER_PATTERN_EN
  logic [15:0] r_x;
  logic [15:0] r_y;

  // Active-pixel coordinates for the grid, advanced on every counted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_vs_fall) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_push) begin
      if (r_x == 16'(HDISP - 1)) begin
        r_x <= '0;
        r_y <= r_y + 16'd1;
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

  assign w_pix = pattern_sel ? grid_pixel(r_x[3:0], r_y[3:0]) : vid_rgb;
`else
  logic w_unused;
  assign w_unused = pattern_sel;
  assign w_pix    = vid_rgb;
`endif

  // Each entry carries its pixel index, so dropped pixels leave a gap in the
  // address sequence and later pixels still land on their own slot.
  assign w_din = {r_cnt, w_pix};

  frame_writer_fifo #(
    .DEPTH_W (DEPTH_W),
    .DATA_W  (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_head_idx  = w_dout[DATA_W-1:24];
  assign w_head_last = (w_head_idx == CNT_W'(NPIX - 1));
  assign w_pop       = wb_ack & ~w_empty;

  // Address after the last ack, frame-done pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr        <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_pop & w_head_last;
      if (w_pop) r_adr <= w_head_last ? 32'd0 : 32'({w_head_idx + CNT_W'(1), 2'b00});
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign wb_stb     = ~w_empty;
  assign wb_cyc     = ~w_empty;
  assign wb_adr     = w_empty ? r_adr : 32'({w_head_idx, 2'b00});
  assign wb_dat_ms  = {8'h00, w_dout[23:0]};
  assign wb_we      = 1'b1;
  assign wb_sel     = WB_SEL_ALL;
  assign wb_cti     = WB_CTI_CLASSIC;
  assign wb_bte     = WB_BTE_LINEAR;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_wshb_frame_writer.sv
// Randomised bench for wshb_frame_writer against a queue-based framebuffer model.
module tb_wshb_frame_writer;

  localparam int unsigned HDISP   = 4;
  localparam int unsigned VDISP   = 2;
  localparam int unsigned DEPTH_W = 2;
  localparam int          NPIX    = HDISP * VDISP;
  localparam int          DEPTH   = 1 << DEPTH_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] vid_rgb = '0;
  logic        vid_blank = 1'b0;
  logic        vid_vs = 1'b1;
  logic        pattern_sel = 1'b0;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_ms;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack = 1'b0;
  logic        frame_done;
  logic        overflow;

  wshb_frame_writer #(.HDISP(HDISP), .VDISP(VDISP), .DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .rst_n(rst_n), .vid_rgb(vid_rgb), .vid_blank(vid_blank),
    .vid_vs(vid_vs), .pattern_sel(pattern_sel), .wb_adr(wb_adr),
    .wb_dat_ms(wb_dat_ms), .wb_we(wb_we), .wb_sel(wb_sel), .wb_cti(wb_cti),
    .wb_bte(wb_bte), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pending writes as (pixel index, colour); address is 4*index.
  typedef struct {
    int          idx;
    logic [23:0] d;
  } ent_t;

  ent_t        m_q[$];
  bit          m_capture;
  int          m_cnt;
  bit          m_vs_prev;
  bit          m_ovf;
  bit          m_fd;
  logic [31:0] m_adr;
  int          ack_mode;
  int          cyc_n;

  function automatic void model_reset();
    m_q.delete();
    m_capture = 0;
    m_cnt     = 0;
    m_vs_prev = 0;
    m_ovf     = 0;
    m_fd      = 0;
    m_adr     = 0;
  endfunction

  function automatic logic [23:0] grid(input int x, input int y);
    return ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  function automatic void model_update(input logic vs, input logic blank,
                                       input logic [23:0] rgb, input logic ack,
                                       input logic psel);
    bit   fall;
    bit   push;
    bit   pop;
    ent_t e;
    logic [23:0] pix;
    fall = m_vs_prev && !vs;
    pop  = ack && (m_q.size() > 0);
    push = 0;
    if (fall) begin
      m_capture = 1;
      m_cnt     = 0;
    end else if (m_capture && blank && m_cnt < NPIX) begin
      push = 1;
    end
    m_fd = 0;
    if (pop) begin
      e     = m_q.pop_front();
      m_fd  = (e.idx == NPIX - 1);
      m_adr = m_fd ? 32'd0 : 32'(4 * (e.idx + 1));
    end
    if (push) begin
      pix = rgb;
`ifdef FRAME_WRITER_PATTERN_EN
      if (psel) pix = grid(m_cnt % HDISP, m_cnt / HDISP);
`endif
      if (m_q.size() >= DEPTH) m_ovf = 1;
      else m_q.push_back('{idx: m_cnt, d: pix});
      m_cnt++;
    end
    m_vs_prev = vs;
    if (psel) begin end
  endfunction

  task automatic compare_outputs();
    logic stb_e;
    stb_e = (m_q.size() > 0);
    check("stb", 32'(wb_stb), 32'(stb_e));
    check("cyc", 32'(wb_cyc), 32'(stb_e));
    check("adr", wb_adr, stb_e ? 32'(4 * m_q[0].idx) : m_adr);
    if (stb_e) check("dat", wb_dat_ms, {8'h00, m_q[0].d});
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: check current outputs, drive new inputs, advance the model.
  task automatic step(input logic vs, input logic blank);
    logic ack;
    @(negedge clk);
    compare_outputs();
    case (ack_mode)
      0:       ack = 1'b1;
      1:       ack = (cyc_n % 3 == 0);
      2:       ack = 1'($urandom_range(1));
      default: ack = 1'b0;
    endcase
    cyc_n++;
    vid_vs    = vs;
    vid_blank = blank;
    vid_rgb   = 24'($urandom);
    wb_ack    = ack;
    model_update(vs, blank, vid_rgb, ack, pattern_sel);
  endtask

  task automatic frame(input int extra, input int gap_pct);
    int active = 0;
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    for (int c = 0; c < 2000 && active < NPIX + extra; c++) begin
      logic b;
      b = ($urandom_range(99) >= gap_pct);
      step(1, b);
      if (b) active++;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && m_q.size() > 0; c++) step(1, 0);
    step(1, 0);
    check("drain_idle", 32'(wb_stb), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    vid_vs    = 1'b1;
    vid_blank = 1'b0;
    wb_ack    = 1'b0;
    #1;
    model_reset();
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_update(vid_vs, vid_blank, vid_rgb, wb_ack, pattern_sel);
  endtask

  initial begin
    model_reset();
    ack_mode = 0;
    cyc_n    = 0;
    apply_reset();
    check("we", 32'(wb_we), 32'd1);
    check("sel", 32'(wb_sel), 32'hF);
    check("cti", 32'(wb_cti), 32'd0);
    check("bte", 32'(wb_bte), 32'd0);

    // Active pixels before any vsync edge are ignored.
    ack_mode = 2;
    for (int i = 0; i < 20; i++) step(1, 1'($urandom_range(1)));

    // Full frames, ack always high, with and without gaps.
    ack_mode = 0;
    frame(0, 0);
    drain();
    frame(3, 30);
    drain();

    // Ack every third cycle and random ack.
    ack_mode = 1;
    frame(2, 0);
    drain();
    ack_mode = 2;
    for (int f = 0; f < 6; f++) begin
      pattern_sel = 1'($urandom_range(1));
      frame(int'($urandom_range(4)), int'($urandom_range(50)));
    end
    drain();
    pattern_sel = 1'b1;
    frame(0, 0);
    drain();
    pattern_sel = 1'b0;

    // Slave stalls while a whole frame arrives: overflow and address gaps.
    ack_mode = 3;
    frame(12, 0);
    for (int i = 0; i < 20; i++) step(1, 0);
    ack_mode = 0;
    drain();
    ack_mode = 2;
    frame(0, 20);
    drain();

    // Reset while a write is outstanding, then capture must wait for vsync.
    ack_mode = 3;
    frame(0, 0);
    apply_reset();
    ack_mode = 2;
    for (int i = 0; i < 10; i++) step(1, 1);
    ack_mode = 0;
    frame(0, 0);
    drain();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
